// File: rtl/y86_instr_encoder.sv
// Serialises one decoded Y86-64 instruction into the byte layout the fetch stage
// decodes, writing one byte per clock to an instruction-memory write port.
module y86_instr_encoder #(
    parameter int MEM_SIZE = 1024,
    parameter int ADDR_W   = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        icode,
    input  logic [3:0]        ifun,
    input  logic [3:0]        rA,
    input  logic [3:0]        rB,
    input  logic [63:0]       valC,
    input  logic [ADDR_W-1:0] addr,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              done,
    output logic [ADDR_W-1:0] next_addr,
    output logic              err_inst,
    output logic              err_mem
);

    typedef enum logic {IDLE, EMIT} state_t;

    localparam logic [ADDR_W:0] MEM_LIMIT = (ADDR_W+1)'(MEM_SIZE);

    state_t state, state_nxt;

    logic [3:0]        icode_q, ifun_q, ra_q, rb_q;
    logic [63:0]       valc_q;
    logic [ADDR_W-1:0] base_q;
    logic [3:0]        len_q;
    logic [3:0]        cnt_q, cnt_d;

    logic              accept;
    logic [3:0]        len_in;
    logic [ADDR_W:0]   end_ext;
    logic              fault_inst, fault_mem;

    logic              we_d, done_d, ei_d, em_d;
    logic [ADDR_W-1:0] addr_d, naddr_d;
    logic [7:0]        wdata_d;

    function automatic logic [3:0] len_of(input logic [3:0] ic);
        case (ic)
            4'h0, 4'h1, 4'h9:       len_of = 4'd1;
            4'h2, 4'h6, 4'hA, 4'hB: len_of = 4'd2;
            4'h3, 4'h4, 4'h5:       len_of = 4'd10;
            4'h7, 4'h8:             len_of = 4'd9;
            default:                len_of = 4'd1;
        endcase
    endfunction

    // k is the byte index within the instruction; valC goes out MSB first.
    function automatic logic [7:0] byte_at(input logic [3:0] ic, input logic [3:0] fn,
                                           input logic [3:0] ra, input logic [3:0] rb,
                                           input logic [63:0] vc, input logic [3:0] k);
        logic       jump;
        logic [3:0] ra_f, rb_f;
        logic [2:0] p;
        jump = (ic == 4'h7) || (ic == 4'h8);
        ra_f = (ic == 4'h3) ? 4'hF : ra;
        rb_f = ((ic == 4'hA) || (ic == 4'hB)) ? 4'hF : rb;
        p    = 3'(jump ? (4'd8 - k) : (4'd9 - k));
        if (k == 4'd0)
            byte_at = {ic, fn};
        else if ((k == 4'd1) && !jump)
            byte_at = {ra_f, rb_f};
        else
            byte_at = vc[{p, 3'b000} +: 8];
    endfunction

    assign in_ready   = (state == IDLE) && !rst;
    assign accept     = in_valid && in_ready;
    assign len_in     = len_of(icode);
    assign end_ext    = {1'b0, addr} + {{(ADDR_W-3){1'b0}}, len_in};
    assign fault_inst = icode > 4'hB;
    assign fault_mem  = end_ext > MEM_LIMIT;

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept && !fault_inst && !fault_mem) state_nxt = EMIT;
            EMIT:    if (cnt_q == len_q) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are registered one cycle ahead: the accept edge already launches byte 0.
    always_comb begin
        we_d    = 1'b0;
        done_d  = 1'b0;
        ei_d    = 1'b0;
        em_d    = 1'b0;
        addr_d  = mem_addr;
        wdata_d = mem_wdata;
        naddr_d = next_addr;
        cnt_d   = cnt_q;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (fault_inst) begin
                        ei_d = 1'b1;
                    end else if (fault_mem) begin
                        em_d = 1'b1;
                    end else begin
                        we_d    = 1'b1;
                        addr_d  = addr;
                        wdata_d = {icode, ifun};
                        cnt_d   = 4'd1;
                        if (len_in == 4'd1) begin
                            done_d  = 1'b1;
                            naddr_d = addr + {{(ADDR_W-4){1'b0}}, len_in};
                        end
                    end
                end
            end
            EMIT: begin
                if (cnt_q != len_q) begin
                    we_d    = 1'b1;
                    addr_d  = base_q + {{(ADDR_W-4){1'b0}}, cnt_q};
                    wdata_d = byte_at(icode_q, ifun_q, ra_q, rb_q, valc_q, cnt_q);
                    cnt_d   = cnt_q + 4'd1;
                    if ((cnt_q + 4'd1) == len_q) begin
                        done_d  = 1'b1;
                        naddr_d = base_q + {{(ADDR_W-4){1'b0}}, len_q};
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            done      <= 1'b0;
            next_addr <= '0;
            err_inst  <= 1'b0;
            err_mem   <= 1'b0;
            cnt_q     <= '0;
        end else begin
            mem_we    <= we_d;
            mem_addr  <= addr_d;
            mem_wdata <= wdata_d;
            done      <= done_d;
            next_addr <= naddr_d;
            err_inst  <= ei_d;
            err_mem   <= em_d;
            cnt_q     <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            icode_q <= icode;
            ifun_q  <= ifun;
            ra_q    <= rA;
            rb_q    <= rB;
            valc_q  <= valC;
            base_q  <= addr;
            len_q   <= len_in;
        end
    end

endmodule

// File: tb/tb_y86_instr_encoder.sv
// Randomised scoreboard bench for y86_instr_encoder: a byte-list reference model
// predicts every write/error pulse, and a monitor compares them as they appear.
module tb_y86_instr_encoder;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready;
    logic [3:0]  icode, ifun, rA, rB;
    logic [63:0] valC, addr;
    logic        mem_we, done, err_inst, err_mem;
    logic [63:0] mem_addr, next_addr;
    logic [7:0]  mem_wdata;

    y86_instr_encoder #(.MEM_SIZE(1024), .ADDR_W(64)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .icode(icode), .ifun(ifun), .rA(rA), .rB(rB), .valC(valC), .addr(addr),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .done(done),
        .next_addr(next_addr), .err_inst(err_inst), .err_mem(err_mem)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        we;
        logic [63:0] a;
        logic [7:0]  d;
        logic        dn;
        logic [63:0] na;
        logic        ei;
        logic        em;
        int          c;
    } ev_t;

    ev_t         q[$];
    ev_t         mon_e;
    logic [7:0]  bytes[$];
    logic [63:0] exp_next = 64'd0;
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference encoding: opcode byte, optional register byte, optional valC big-endian.
    function automatic void build(input logic [3:0] ic, input logic [3:0] fn,
                                  input logic [3:0] ra, input logic [3:0] rb,
                                  input logic [63:0] vc);
        logic has_reg, has_val;
        logic [3:0] a, b;
        bytes.delete();
        has_reg = (ic inside {4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB});
        has_val = (ic inside {4'h3, 4'h4, 4'h5, 4'h7, 4'h8});
        a = (ic == 4'h3) ? 4'hF : ra;
        b = (ic == 4'hA || ic == 4'hB) ? 4'hF : rb;
        bytes.push_back({ic, fn});
        if (has_reg) bytes.push_back({a, b});
        if (has_val)
            for (int i = 7; i >= 0; i--) bytes.push_back(vc[8*i +: 8]);
    endfunction

    task automatic issue(input logic [3:0] ic, input logic [3:0] fn, input logic [3:0] ra,
                         input logic [3:0] rb, input logic [63:0] vc, input logic [63:0] ad,
                         input bit garbage);
        int   d, len, n;
        logic ei, em;
        ev_t  e;
        build(ic, fn, ra, rb, vc);
        len = bytes.size();
        ei  = ic > 4'hB;
        em  = !ei && (ad > 64'(1024 - len));
        icode = ic; ifun = fn; rA = ra; rB = rb; valC = vc; addr = ad;
        in_valid = 1'b1;
        d = cyc;
        if (ei || em) begin
            e.we = 1'b0; e.a = 64'd0; e.d = 8'd0; e.dn = 1'b0; e.na = exp_next;
            e.ei = ei; e.em = em; e.c = d + 1;
            q.push_back(e);
        end else begin
            for (int k = 0; k < len; k++) begin
                e.we = 1'b1; e.a = ad + 64'(k); e.d = bytes[k];
                e.dn = (k == len - 1);
                e.na = e.dn ? ad + 64'(len) : exp_next;
                e.ei = 1'b0; e.em = 1'b0; e.c = d + 1 + k;
                q.push_back(e);
            end
            exp_next = ad + 64'(len);
        end
        @(negedge clk);
        n = 0;
        while (in_ready !== 1'b1 && n < 40) begin
            in_valid = garbage;
            if (garbage) begin
                icode = 4'($urandom); ifun = 4'($urandom); rA = 4'($urandom); rB = 4'($urandom);
                valC = {$urandom, $urandom}; addr = 64'($urandom_range(0, 2000));
            end
            @(negedge clk);
            n++;
        end
        in_valid = 1'b0;
        chk("ready_latency", 64'(cyc - d), (ei || em) ? 64'd1 : 64'(len + 1));
    endtask

    always begin
        @(posedge clk);
        #1;
        if (mem_we === 1'b1 || done === 1'b1 || err_inst === 1'b1 || err_mem === 1'b1) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output we=%0b addr=%0h data=%0h done=%0b ei=%0b em=%0b required=none",
                         mem_we, mem_addr, mem_wdata, done, err_inst, err_mem);
            end else begin
                mon_e = q.pop_front();
                chk("cycle", 64'(cyc), 64'(mon_e.c));
                chk("mem_we", {63'd0, mem_we}, {63'd0, mon_e.we});
                if (mon_e.we) begin
                    chk("mem_addr", mem_addr, mon_e.a);
                    chk("mem_wdata", {56'd0, mem_wdata}, {56'd0, mon_e.d});
                end
                chk("done", {63'd0, done}, {63'd0, mon_e.dn});
                chk("next_addr", next_addr, mon_e.na);
                chk("err_inst", {63'd0, err_inst}, {63'd0, mon_e.ei});
                chk("err_mem", {63'd0, err_mem}, {63'd0, mon_e.em});
            end
        end
    end

    initial begin
        int          d, n, len;
        logic [3:0]  ic;
        logic [63:0] ad;
        rst = 1'b1; in_valid = 1'b0;
        icode = 4'd0; ifun = 4'd0; rA = 4'd0; rB = 4'd0; valC = 64'd0; addr = 64'd0;
        repeat (3) @(negedge clk);
        chk("rst_mem_we", {63'd0, mem_we}, 64'd0);
        chk("rst_mem_addr", mem_addr, 64'd0);
        chk("rst_mem_wdata", {56'd0, mem_wdata}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_next_addr", next_addr, 64'd0);
        chk("rst_errs", {62'd0, err_inst, err_mem}, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
        rst = 1'b0;
        #1;
        chk("ready_after_rst", {63'd0, in_ready}, 64'd1);

        issue(4'h3, 4'h0, 4'h0, 4'h3, 64'h0000000000020004, 64'd2, 1'b0);
        issue(4'h1, 4'h0, 4'h0, 4'h0, 64'd0, 64'd14, 1'b1);
        issue(4'h6, 4'h0, 4'h2, 4'h2, 64'd0, 64'd15, 1'b0);
        issue(4'h7, 4'h3, 4'h0, 4'h0, 64'h200, 64'd17, 1'b1);
        issue(4'hA, 4'h0, 4'h3, 4'h0, 64'd0, 64'd12, 1'b0);
        issue(4'hC, 4'h0, 4'h0, 4'h0, 64'd0, 64'd0, 1'b0);
        issue(4'h3, 4'h0, 4'h0, 4'h5, 64'h1122334455667788, 64'd1015, 1'b0);
        issue(4'h3, 4'h0, 4'h0, 4'h5, 64'h1122334455667788, 64'd1014, 1'b0);
        issue(4'h1, 4'h0, 4'h0, 4'h0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
        issue(4'hF, 4'h0, 4'h0, 4'h0, 64'd0, 64'd5000, 1'b0);
        issue(4'h0, 4'h0, 4'h0, 4'h0, 64'd0, 64'd1023, 1'b0);

        // Reset in the cycle that writes byte 3 of an rmmov.
        build(4'h4, 4'h0, 4'h1, 4'h2, 64'hA1B2C3D4E5F60718);
        icode = 4'h4; ifun = 4'h0; rA = 4'h1; rB = 4'h2; valC = 64'hA1B2C3D4E5F60718; addr = 64'd100;
        in_valid = 1'b1;
        d = cyc;
        for (int k = 0; k < 4; k++) begin
            ev_t e;
            e.we = 1'b1; e.a = 64'd100 + 64'(k); e.d = bytes[k]; e.dn = 1'b0; e.na = exp_next;
            e.ei = 1'b0; e.em = 1'b0; e.c = d + 1 + k;
            q.push_back(e);
        end
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (cyc != d + 4 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("rst_wait", 64'(cyc), 64'(d + 4));
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_mem_we", {63'd0, mem_we}, 64'd0);
        chk("midrst_done", {63'd0, done}, 64'd0);
        chk("midrst_next_addr", next_addr, 64'd0);
        chk("midrst_in_ready", {63'd0, in_ready}, 64'd0);
        rst = 1'b0;
        exp_next = 64'd0;
        #1;
        chk("midrst_ready_after", {63'd0, in_ready}, 64'd1);
        issue(4'h1, 4'h5, 4'h0, 4'h0, 64'd0, 64'd40, 1'b0);

        for (int i = 0; i < 40; i++) begin
            ic = 4'($urandom_range(0, 15));
            build(ic, 4'd0, 4'd0, 4'd0, 64'd0);
            len = bytes.size();
            case ($urandom_range(0, 9))
                0:       ad = 64'(1024 - len + $urandom_range(0, 2));
                1:       ad = 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(0, 15));
                default: ad = 64'($urandom_range(0, 1000));
            endcase
            issue(ic, 4'($urandom), 4'($urandom), 4'($urandom), {$urandom, $urandom}, ad,
                  bit'($urandom_range(0, 1)));
        end

        n = 0;
        while (q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 64'(q.size()), 64'd0);
        chk("final_next_addr", next_addr, exp_next);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/y86_instr_encoder.md
Name: y86_instr_encoder

Overview:
- Encoder/writer counterpart to the sequential fetch stage.
- Takes one decoded Y86-64 instruction (icode, ifun, rA, rB, valC) plus a target address.
- Serializes it into the exact byte layout that fetch decodes, one byte per clock, onto an instruction-memory write port.
- Used by the loader/bench path to populate instruction memory in place of hand-written byte initialisation.

Parameters:
- MEM_SIZE, 1024: instruction memory depth in bytes; valid addresses 0..MEM_SIZE-1.
- ADDR_W, 64: width of the address and next_addr fields.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  instruction fields and addr are valid this cycle
- in_ready  output  1  encoder can accept; combinational = (state==IDLE) && !rst
- icode  input  4  instruction code
- ifun  input  4  function code
- rA  input  4  register A
- rB  input  4  register B
- valC  input  64  constant word
- addr  input  ADDR_W  byte address of the first instruction byte
- mem_we  output  1  byte write strobe
- mem_addr  output  ADDR_W  write address
- mem_wdata  output  8  write data
- done  output  1  one-cycle pulse, coincident with the last byte write
- next_addr  output  ADDR_W  addr + length of the last completed instruction (valP equivalent)
- err_inst  output  1  one-cycle pulse: icode > 4'hB
- err_mem  output  1  one-cycle pulse: instruction would cross MEM_SIZE-1

Behaviour:
- Reset: all registered outputs are 0 (mem_we, mem_addr, mem_wdata, done, next_addr, err_inst, err_mem). State = IDLE.
- FSM:
  - IDLE: in_valid && in_ready accepts. Fields, length, start address and byte index 0 are latched.
  - An accepted instruction with no error goes to EMIT. An error stays in IDLE.
  - EMIT: issues one byte per cycle; after the last byte, returns to IDLE.
- Length by icode:
  - 0 halt, 1 nop, 9 ret: 1 byte
  - 2 cmov/rrmov, 6 op, A push, B pop: 2 bytes
  - 3 irmov, 4 rmmov, 5 mrmov: 10 bytes
  - 7 jXX, 8 call: 9 bytes
- Byte 0 = {icode, ifun}.
- Register byte = {rA, rB}, with forced fields:
  - irmov: rA forced to 4'hF.
  - push/pop: rB forced to 4'hF.
  - All other icodes use rA/rB as supplied.
- valC is emitted most-significant byte first (big-endian), matching fetch's concatenation order:
  - icodes 3/4/5: bytes 2..9 = valC[63:56] .. valC[7:0].
  - icodes 7/8: bytes 1..8 = valC[63:56] .. valC[7:0].
  - ifun is written as supplied for all icodes.
- Timing (accept at cycle 0):
  - Byte k is written in cycle k+1 with mem_addr = addr+k and mem_we=1.
  - done=1 in cycle len, together with the final write.
  - next_addr updates to addr+len in cycle len.
  - in_ready is high again in cycle len+1.
  - Back-to-back throughput is one instruction per len+1 cycles.
- mem_we is 0 in every cycle that is not an EMIT write; mem_addr/mem_wdata hold their last values.
- in_valid while busy is ignored; the input is not latched and state is unaffected.
- Errors are checked at accept:
  - err_inst: icode in C..F.
  - err_mem: addr > MEM_SIZE-len, including addr >= MEM_SIZE. Compare with zero-extended arithmetic; no wrap.
  - On error: a pulse the next cycle, no writes, done=0, next_addr unchanged, in_ready stays 1.
  - If both conditions hold, err_inst takes priority and err_mem=0.
- Exact fit is legal: addr+len == MEM_SIZE writes the final byte at MEM_SIZE-1.
- rst during EMIT:
  - Next cycle: mem_we=0, all outputs at reset values, state IDLE.
  - Bytes already written remain in memory; no done pulse.

Test Plan:
- irmov (icode 3, ifun 0, rA 0, rB 3, valC 64'h0000000000020004) at addr 2:
  - Cycles 1..10 write 30,F3,00,00,00,00,00,02,00,04 to addr 2..11.
  - done in cycle 10, next_addr=12.
- nop at addr 14 then op (6,0,rA 2,rB 2) at addr 15, back-to-back in_valid:
  - Writes 10@14, then 60@15, 22@16.
  - in_valid in the op's first cycle is held off until in_ready=1.
  - Final next_addr=17.
- jXX (7,3,valC 64'h200) at addr 17: writes 73,00,00,00,00,00,00,02,00 to addr 17..25, next_addr=26.
- pushq with rA 3, rB 0 supplied at addr 12: writes A0,3F (rB forced F), next_addr=14.
- Error cases:
  - icode C at addr 0: err_inst=1 for one cycle, no mem_we.
  - irmov at addr 1015: err_mem=1, no writes.
  - irmov at addr 1014: 10 writes ending at 1023, done=1.
- Reset mid-emission: assert rst in the cycle writing the 4th byte of an rmmov.
  - Next cycle mem_we=0, done=0, next_addr=0.
  - in_ready=1 once rst deasserts, and a new nop is accepted and written correctly.
